// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the multiplier state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/sub of M, then arithmetic right shift.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q1,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q1
);

    logic [WIDTH:0] w_ext;
    logic [WIDTH:0] w_sum;

    assign w_ext = {i_m[WIDTH-1], i_m};

    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_q1})
            2'b01:   w_sum = i_a + w_ext;
            2'b10:   w_sum = i_a - w_ext;
            default: w_sum = i_a;
        endcase
    end

    // Shift {A, Q, q_1} right by one, replicating the accumulator sign bit.
    assign o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q  = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_q1 = i_q[0];

endmodule

// File: rtl/booth_mul_z.sv
// Sequential signed Booth multiplier writing a 2*WIDTH product into the Z register.
import alu_pkg::*;

module booth_mul_z #(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo
);

    mul_state_t       r_state;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [WIDTH-1:0] r_m;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_a_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic             w_q1_nx;
    logic             w_last;

    booth_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_a  (r_a),
        .i_q  (r_q),
        .i_q1 (r_q1),
        .i_m  (r_m),
        .o_a  (w_a_nx),
        .o_q  (w_q_nx),
        .o_q1 (w_q1_nx)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= a;
                        r_a     <= '0;
                        r_q     <= b;
                        r_q1    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= w_a_nx;
                    r_q   <= w_q_nx;
                    r_q1  <= w_q1_nx;
                    r_cnt <= r_cnt + 1'b1;
                    // Z is loaded from the last step's output in the same edge.
                    if (w_last) begin
                        r_hi    <= w_a_nx[WIDTH-1:0];
                        r_lo    <= w_q_nx;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign z_hi = r_hi;
    assign z_lo = r_lo;

endmodule

// File: tb/tb_booth_mul_z.sv
// Scoreboard bench for booth_mul_z: directed, random and reset-abort operations.
module tb_booth_mul_z;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] z_hi;
    logic [31:0] z_lo;

    int tests;
    int fails;
    logic [63:0] exp_q[$];
    logic [63:0] prev_z;

    booth_mul_z #(
        .WIDTH(32),
        .CNT_W(5)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .z_hi  (z_hi),
        .z_lo  (z_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse pops one expected product.
    always @(negedge clk) begin
        if (clr_n && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got %h expected none",
                         {z_hi, z_lo});
            end else begin
                chk("product", {z_hi, z_lo}, exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [63:0] ex, input bit mess);
        int k;
        int busy_n;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        exp_q.push_back(ex);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (mess) begin
            a = ~ta;
            b = tb_v ^ 32'h5A5A_0F0F;
        end
        busy_n = 0;
        for (k = 0; k < 40; k++) begin
            if (busy) busy_n++;
            if (done) break;
            if (k == 20) chk("z_hold", {z_hi, z_lo}, prev_z);
            if (mess && k == 10) start = 1'b1;
            if (mess && k == 12) start = 1'b0;
            @(negedge clk);
        end
        chk("latency", 64'(k), 64'd32);
        chk("busy_cycles", 64'(busy_n), 64'd33);
        @(negedge clk);
        chk("done_pulse", {62'd0, done, busy}, 64'd0);
        prev_z = ex;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        longint      p;
        tests  = 0;
        fails  = 0;
        prev_z = 64'd0;
        clr_n  = 1'b0;
        start  = 1'b1;
        a      = 32'd6;
        b      = 32'd7;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_out", {z_hi, z_lo}, 64'd0);
        chk("reset_ctl", {62'd0, busy, done}, 64'd0);
        start = 1'b0;
        clr_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold", {62'd0, busy, done}, 64'd0);

        do_op(32'd6, 32'd7, 64'd42, 1'b0);
        do_op(-32'sd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        do_op(-32'sd3, -32'sd5, 64'd15, 1'b0);
        do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 1'b0);
        do_op(32'd100, -32'sd9, 64'hFFFF_FFFF_FFFF_FC7C, 1'b1);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            p  = longint'($signed(ra)) * longint'($signed(rb));
            do_op(ra, rb, 64'(p), (i % 8) == 0);
        end

        // Abort a run at step 17; nothing may be delivered.
        @(negedge clk);
        a = 32'd77;
        b = 32'd55;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        clr_n = 1'b0;
        #1;
        chk("abort_z", {z_hi, z_lo}, 64'd0);
        chk("abort_ctl", {62'd0, busy, done}, 64'd0);
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        prev_z = 64'd0;
        repeat (40) @(negedge clk);
        chk("abort_silent", {62'd0, busy, done}, 64'd0);
        do_op(32'd12345, -32'sd2, 64'hFFFF_FFFF_FFFF_9F8E, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
